bmp_stream_processor: RTL
=========================

# bmp_stream_processor

Parametrised successor to the single-mode slave-0 path of `image_processing_acclerator`. It accepts a BMP file as a stream of byte-packed beats, parses the header on the fly and passes it through unchanged. Pixel bytes go through a per-frame selectable saturating operation. Results stream out on a master port with back-pressure, and a completion pulse marks the final beat of the file.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: beat width in bits. Must be a multiple of 8 and at least 32. `BYTES = DATA_WIDTH/8`.
- `COLOR_SIZE`, default 8: width of the operand and of each colour byte. Fixed at 8 in this generation.
- `HDR_BYTES`, default 54: minimum header length. Bytes at indices below this are never processed.

**Ports**
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst_n` in 1: reset. Asynchronous and active-low.
- `slv0_mode` in 2: operation select. Sampled only on the first accepted beat of a file.
- `slv0_proc_val` in `COLOR_SIZE`: operand. Sampled together with `slv0_mode`.
- `slv0_data` in `DATA_WIDTH`: input beat. File byte k is on bits [8·(k mod BYTES) +: 8].
- `slv0_data_valid` in 1: input beat valid.
- `slv0_ready` out 1: block can accept a beat.
- `mstr0_data` out `DATA_WIDTH`: output beat, same lane order as input.
- `mstr0_data_valid` out 1: output beat valid.
- `mstr0_ready` in 1: downstream accepts.
- `mstr0_cmplt` out 1: high with the last output beat of the file.
- `hdr_file_size` out 32: BMP file size, bytes 2..5 little-endian.
- `hdr_data_pos` out 32: pixel data offset, bytes 10..13.
- `hdr_width` out 32: width, bytes 18..21.
- `hdr_height` out 32: height, bytes 22..25.
- `hdr_bpp` out 16: bits per pixel, bytes 28..29.
- `hdr_valid` out 1: all header fields captured, i.e. byte 29 has been accepted.

## Operation

**State machine**
- States are IDLE, HEADER, PIXEL, LAST.
- IDLE → HEADER on the first accepted beat. On that beat, latch `slv0_mode`/`slv0_proc_val` and clear the byte counter `bcnt` (32 bits).
- HEADER → PIXEL when `hdr_valid` is set and `bcnt` ≥ `hdr_data_pos`.
- Any state → LAST when the accepted beat covers byte index `hdr_file_size`−1. End detection is enabled only once bytes 2..5 have been captured.
- LAST → IDLE when that beat is handed off downstream (`mstr0_data_valid && mstr0_ready`).

**Byte handling**
- Each beat accepted advances `bcnt` by `BYTES`.
- Header capture is per byte by global index, so fields may straddle beats.
- A byte with index below `max(hdr_data_pos, HDR_BYTES)` passes through unmodified.
- A byte with index at or above `hdr_file_size` is driven as 0x00 in the final beat.
- Any other byte is a pixel byte and gets the latched operation.

**Operations (8-bit, unsigned)**
- 00: bypass.
- 01: `min(p + v, 255)`.
- 10: `max(p − v, 0)`.
- 11: threshold, `p ≥ v ? 0xFF : 0x00`.
- Sum and difference are computed at 9 bits and then saturated. There is no wrap-around.

**Frame boundaries**
- Header registers and `hdr_valid` are cleared on the IDLE→HEADER transition, so back-to-back files are independent.
- A beat accepted in LAST belongs to the next file only after the return to IDLE. `slv0_ready` is 0 while in LAST.

## Timing

**Reset**
- Outputs reset to: `slv0_ready` 0, `mstr0_data_valid` 0, `mstr0_cmplt` 0, `mstr0_data` 0, all `hdr_*` 0, state IDLE.
- `slv0_ready` rises on the first clock edge after `rst_n` deasserts.
- Assertion mid-file aborts immediately. The output beat is discarded and no `mstr0_cmplt` is issued.

**Pipeline and handshake**
- Single registered output stage. Latency is 1 cycle from input acceptance to `mstr0_data_valid`.
- `slv0_ready = (state != LAST) && (!mstr0_data_valid || mstr0_ready)`. This gives a throughput of one beat per cycle under no stall.
- `mstr0_data`, `mstr0_data_valid` and `mstr0_cmplt` hold stable while `mstr0_data_valid && !mstr0_ready`.
- `mstr0_cmplt` is asserted only together with `mstr0_data_valid`, and drops after the handshake.
- A `slv0_mode` change mid-file has no effect.

## Test plan

All scenarios use `DATA_WIDTH`=32 and a 58-byte file: file size 58, data offset 54, width 1, height 1, bpp 24, pixel bytes 54..57 = 10 80 F0 00.

1. **Bypass.** Mode 00, `mstr0_ready` held at 1. Expect 15 output beats identical to input, except beat 14 lanes 2..3 = 00. `mstr0_cmplt` is high only on beat 14. `hdr_*` = 58/54/1/1/24.
2. **Add.** Mode 01, operand 0x20. Pixel bytes become 30 A0 FF 20. Header bytes 0..53 are unchanged.
3. **Threshold.** Mode 11, operand 0x80. Pixel bytes become 00 FF FF 00. Then a second file with mode 10 and operand 0x20 follows immediately; its pixel bytes become 00 60 D0 00, and `hdr_valid` is cleared between the two files.
4. **Back-pressure.** Mode 01, `mstr0_ready` toggles every cycle. The output sequence must match scenario 2 exactly. `slv0_ready` is 0 during stalled cycles, and output data stays stable while stalled.
5. **Reset mid-file.** Assert `rst_n`=0 after 5 beats. All outputs return to reset values asynchronously. Restarting the file with mode 00 reproduces scenario 1 exactly.

Source files
------------

// File: rtl/bmp_stream_processor.sv
`default_nettype none
// ============================================================================
// Module   : bmp_stream_processor
// Brief    : Streams a BMP file through, capturing header fields and applying
//            a per-frame saturating operation to pixel bytes.
// Revision : 1.0 - initial release
// ============================================================================
module bmp_stream_processor #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = 8,
    parameter int HDR_BYTES  = 54
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            slv0_mode,
    input  logic [COLOR_SIZE-1:0] slv0_proc_val,
    input  logic [DATA_WIDTH-1:0] slv0_data,
    input  logic                  slv0_data_valid,
    output logic                  slv0_ready,
    output logic [DATA_WIDTH-1:0] mstr0_data,
    output logic                  mstr0_data_valid,
    input  logic                  mstr0_ready,
    output logic                  mstr0_cmplt,
    output logic [31:0]           hdr_file_size,
    output logic [31:0]           hdr_data_pos,
    output logic [31:0]           hdr_width,
    output logic [31:0]           hdr_height,
    output logic [15:0]           hdr_bpp,
    output logic                  hdr_valid
);

    localparam int          c_lanes     = DATA_WIDTH / 8;
    localparam logic [31:0] c_lane_step = 32'(c_lanes);
    localparam logic [31:0] c_hdr_min   = 32'(HDR_BYTES);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_header = 2'd1;
    localparam logic [1:0] c_st_pixel  = 2'd2;
    localparam logic [1:0] c_st_last   = 2'd3;

    logic [1:0]            r_state;
    logic [31:0]           r_bcnt;
    logic [1:0]            r_mode;
    logic [COLOR_SIZE-1:0] r_val;
    logic                  r_fs_ok;
    logic                  r_run;

    logic                  w_acc;
    logic                  w_idle;
    logic [31:0]           w_base;
    logic [31:0]           w_bcnt_nxt;
    logic [1:0]            w_mode;
    logic [COLOR_SIZE-1:0] w_val;
    logic [31:0]           w_idx [c_lanes];
    logic [31:0]           w_fs;
    logic [31:0]           w_dp;
    logic [31:0]           w_wd;
    logic [31:0]           w_ht;
    logic [15:0]           w_bpp;
    logic                  w_fs_ok;
    logic                  w_hvalid;
    logic                  w_end;
    logic [31:0]           w_pix_start;
    logic [DATA_WIDTH-1:0] w_proc;

    function automatic logic [COLOR_SIZE-1:0] apply_op(
        input logic [1:0]            mode,
        input logic [COLOR_SIZE-1:0] p,
        input logic [COLOR_SIZE-1:0] v
    );
        logic [COLOR_SIZE:0] sum;
        logic [COLOR_SIZE:0] dif;
        sum = {1'b0, p} + {1'b0, v};
        dif = {1'b0, p} - {1'b0, v};
        case (mode)
            2'b00:   apply_op = p;
            2'b01:   apply_op = sum[COLOR_SIZE] ? '1 : sum[COLOR_SIZE-1:0];
            2'b10:   apply_op = dif[COLOR_SIZE] ? '0 : dif[COLOR_SIZE-1:0];
            default: apply_op = (p >= v) ? '1 : '0;
        endcase
    endfunction

    assign slv0_ready = r_run && (r_state != c_st_last) && (!mstr0_data_valid || mstr0_ready);
    assign w_acc      = slv0_data_valid && slv0_ready;
    assign w_idle     = (r_state == c_st_idle);
    assign w_base     = w_idle ? 32'd0 : r_bcnt;
    assign w_bcnt_nxt = w_base + c_lane_step;
    assign w_mode     = w_idle ? slv0_mode : r_mode;
    assign w_val      = w_idle ? slv0_proc_val : r_val;

    // Header fields merged with this beat's bytes, so a field completed in
    // the current beat already governs that beat's own pixel bytes.
    always_comb begin
        w_fs     = w_idle ? 32'd0 : hdr_file_size;
        w_dp     = w_idle ? 32'd0 : hdr_data_pos;
        w_wd     = w_idle ? 32'd0 : hdr_width;
        w_ht     = w_idle ? 32'd0 : hdr_height;
        w_bpp    = w_idle ? 16'd0 : hdr_bpp;
        w_fs_ok  = !w_idle && r_fs_ok;
        w_hvalid = !w_idle && hdr_valid;
        for (int i = 0; i < c_lanes; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (w_idx[i] == 32'(2 + k))  w_fs[8*k +: 8] = slv0_data[8*i +: 8];
                if (w_idx[i] == 32'(10 + k)) w_dp[8*k +: 8] = slv0_data[8*i +: 8];
                if (w_idx[i] == 32'(18 + k)) w_wd[8*k +: 8] = slv0_data[8*i +: 8];
                if (w_idx[i] == 32'(22 + k)) w_ht[8*k +: 8] = slv0_data[8*i +: 8];
            end
            for (int k = 0; k < 2; k++) begin
                if (w_idx[i] == 32'(28 + k)) w_bpp[8*k +: 8] = slv0_data[8*i +: 8];
            end
            if (w_idx[i] == 32'd5)  w_fs_ok  = 1'b1;
            if (w_idx[i] == 32'd29) w_hvalid = 1'b1;
        end
    end

    // Overshoot also counts as end so a malformed size can never stall the block.
    assign w_end       = w_fs_ok && (w_fs <= w_bcnt_nxt);
    assign w_pix_start = (w_dp > c_hdr_min) ? w_dp : c_hdr_min;

    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
        logic [7:0] w_in;
        assign w_idx[i] = w_base + 32'(i);
        assign w_in     = slv0_data[8*i +: 8];
        assign w_proc[8*i +: 8] = (w_fs_ok && (w_idx[i] >= w_fs)) ? 8'h00 :
                                  (w_idx[i] < w_pix_start)        ? w_in  :
                                  apply_op(w_mode, w_in, w_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_st_idle;
            r_bcnt           <= 32'd0;
            r_mode           <= 2'b00;
            r_val            <= '0;
            r_fs_ok          <= 1'b0;
            r_run            <= 1'b0;
            hdr_file_size    <= 32'd0;
            hdr_data_pos     <= 32'd0;
            hdr_width        <= 32'd0;
            hdr_height       <= 32'd0;
            hdr_bpp          <= 16'd0;
            hdr_valid        <= 1'b0;
            mstr0_data       <= '0;
            mstr0_data_valid <= 1'b0;
            mstr0_cmplt      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                r_bcnt        <= w_bcnt_nxt;
                r_mode        <= w_mode;
                r_val         <= w_val;
                r_fs_ok       <= w_fs_ok;
                hdr_file_size <= w_fs;
                hdr_data_pos  <= w_dp;
                hdr_width     <= w_wd;
                hdr_height    <= w_ht;
                hdr_bpp       <= w_bpp;
                hdr_valid     <= w_hvalid;
                if (w_end) begin
                    r_state <= c_st_last;
                end else if (w_idle) begin
                    r_state <= c_st_header;
                end else if ((r_state == c_st_header) && w_hvalid && (w_bcnt_nxt >= w_dp)) begin
                    r_state <= c_st_pixel;
                end
            end else if ((r_state == c_st_last) && mstr0_data_valid && mstr0_ready) begin
                r_state <= c_st_idle;
            end

            if (!mstr0_data_valid || mstr0_ready) begin
                mstr0_data_valid <= w_acc;
                mstr0_cmplt      <= w_acc && w_end;
                if (w_acc) begin
                    mstr0_data <= w_proc;
                end
            end
        end
    end

endmodule
`default_nettype wire
